// File: rtl/shift_deser_rx.sv
// Serial-to-parallel receiver: rebuilds N-bit words from a strobed MSB- or LSB-first bit stream
// and holds each finished word in a one-entry valid/ready buffer with sticky error flags.
module shift_deser_rx #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         dir,
  input  logic         s_in,
  input  logic         s_valid,
  input  logic         s_start,
  output logic [N-1:0] m_data,
  output logic         m_valid,
  input  logic         m_ready,
  output logic         busy,
  output logic         overrun,
  output logic         frame_err,
  input  logic         clr_err
);

  localparam int unsigned CntW = $clog2(N + 1);

  typedef enum logic [0:0] {StIdle, StShift} state_e;

  state_e          state_q, state_d;
  logic [N-1:0]    sr_q, sr_d, sr_base, word;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            dir_q, dir_d;
  logic            restart, accept, complete, eff_dir;

  always_comb begin
    restart  = s_valid & s_start;
    accept   = s_valid & (s_start | (state_q == StShift));
    // A start bit always re-latches direction and begins from a cleared register.
    eff_dir  = restart ? dir : dir_q;
    sr_base  = restart ? '0 : sr_q;
    word     = eff_dir ? {s_in, sr_base[N-1:1]} : {sr_base[N-2:0], s_in};
    complete = accept & ~restart & (cnt_q == CntW'(N - 1));

    state_d = state_q;
    sr_d    = sr_q;
    cnt_d   = cnt_q;
    dir_d   = dir_q;
    if (accept) begin
      sr_d  = word;
      dir_d = eff_dir;
      if (complete) begin
        state_d = StIdle;
        cnt_d   = '0;
      end else begin
        state_d = StShift;
        cnt_d   = restart ? CntW'(1) : cnt_q + CntW'(1);
      end
    end
  end

  assign busy = (state_q == StShift);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      sr_q    <= '0;
      cnt_q   <= '0;
      dir_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      sr_q    <= sr_d;
      cnt_q   <= cnt_d;
      dir_q   <= dir_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      m_data    <= '0;
      m_valid   <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      if (complete && (!m_valid || m_ready)) begin
        m_data  <= word;
        m_valid <= 1'b1;
      end else if (m_valid && m_ready) begin
        m_valid <= 1'b0;
      end
      // Set events take priority over clr_err.
      overrun   <= (overrun & ~clr_err) | (complete & m_valid & ~m_ready);
      frame_err <= (frame_err & ~clr_err) | (restart & (state_q == StShift));
    end
  end

endmodule

// File: doc/shift_deser_rx.md
Name: shift_deser_rx

Overview:
Serial-to-parallel receiver. It reassembles N-bit words from a strobed serial bit stream produced by the team's universal shift register when that register is used as a serializer. Both shift directions are supported: MSB-first (the left-shift stream) and LSB-first (the right-shift stream). Each completed word goes into a single-entry output buffer with a valid/ready handshake, plus sticky error flags.

Parameters:
N, 4, word width in bits; legal range N >= 2.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
dir  input  1  bit order; 0 = MSB first (new bit enters LSB), 1 = LSB first (new bit enters MSB); sampled with the start bit
s_in  input  1  serial data bit
s_valid  input  1  bit strobe; s_in is sampled only when s_valid=1
s_start  input  1  marks the first bit of a word; qualified by s_valid
m_data  output  N  assembled word
m_valid  output  1  m_data holds an unconsumed word
m_ready  input  1  consumer accepts m_data when m_valid & m_ready
busy  output  1  1 while a frame is partially received (state SHIFT)
overrun  output  1  sticky; a completed word was dropped because the buffer was full
frame_err  output  1  sticky; s_start arrived mid-frame
clr_err  input  1  synchronous clear of overrun and frame_err

Behaviour:
- Reset (async, immediate): state=IDLE, shift reg=0, bit count=0, latched dir=0, m_data=0, m_valid=0, busy=0, overrun=0, frame_err=0.
- Shift rule, applied on every accepted bit:
  - latched dir=0: sr_next = {sr[N-2:0], s_in}
  - latched dir=1: sr_next = {s_in, sr[N-1:1]}
  - Word = sr_next at the edge the Nth bit is accepted.
- FSM states are IDLE and SHIFT.
- IDLE:
  - s_valid & !s_start: bit ignored.
  - s_valid & s_start: latch dir, shift in s_in from a cleared register, count=1, go to SHIFT.
- SHIFT:
  - s_valid=0: hold all state. Gaps of any length are allowed.
  - s_valid & !s_start: shift, count++.
  - s_valid & s_start (resync): set frame_err, discard the partial word, restart as in IDLE (clear reg, shift in s_in, count=1, re-latch dir). Stay in SHIFT.
  - Completion: when the accepted bit is the Nth, go to IDLE and count=0.
- Completion / output buffer, evaluated at the completion edge:
  - Buffer free (m_valid=0, or m_valid & m_ready this cycle): m_data <= word, m_valid <= 1. Visible the cycle after the Nth strobe, so latency is 1 clk.
  - Buffer full (m_valid & !m_ready): word dropped, m_data unchanged, overrun <= 1.
- Handshake:
  - m_valid deasserts on the edge where m_valid & m_ready, unless a completion happens in the same cycle; in that case m_valid stays 1 with the new data.
  - m_data is stable while m_valid=1 and m_ready=0.
- busy = (state==SHIFT). It is combinational from state.
- clr_err clears both sticky flags at the edge. If a set event occurs in the same cycle, set wins.
- dir changes mid-frame are ignored; only the latched value is used.
- Reset asserted mid-frame: the partial word is lost and no m_valid is produced. After reset the first word needs a fresh s_start.

Test Plan:
- MSB-first: dir=0, strobe bits 1,0,1,1 (s_start on first), m_ready=1 → one cycle after the 4th strobe m_data=4'b1011, m_valid=1 for exactly 1 cycle, busy high during bits 1-3 only.
- LSB-first with gaps: dir=1, bits 1,1,0,1 with 2 idle cycles between strobes → m_data=4'b1011, m_valid=1. dir toggled mid-frame has no effect.
- Backpressure/overrun: m_ready=0, send 4'hA then 4'h5 → m_data stays 4'hA, overrun=1. Raise m_ready → m_valid drops. Pulse clr_err → overrun=0.
- Simultaneous consume and complete: m_valid=1 holding 4'h3, m_ready=1 in the same cycle as the 4th bit of 4'hC → m_valid stays 1, m_data=4'hC, overrun=0.
- Resync: dir=0, send 2 bits, then s_start with bits 0,1,1,0 → frame_err=1, m_data=4'b0110, no word from the aborted frame.
- Reset mid-frame: assert rst after 2 of 4 bits → all outputs 0 immediately. Then bits without s_start are ignored, and a full framed word 4'h9 → m_data=4'h9.
